// File: rtl/internal_mem_responder_pkg.sv
// Shared constants and state encoding for the cache-side memory responder.
package internal_mem_responder_pkg;

   localparam int BW_WORD_ADDR  = 16;
   localparam int BW_BLOCK_LOG2 = 2;
   localparam int N_BLK         = 2 ** BW_BLOCK_LOG2;
   localparam int BW_DATA       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

endpackage

// File: rtl/internal_mem_responder_if.sv
// Cache request/data handshake plus SRAM backend bus of the memory responder.
interface internal_mem_responder_if
   import internal_mem_responder_pkg::*;
#(
   parameter int BW_ADDR     = BW_WORD_ADDR,
   parameter int BW_MEM_ADDR = 14
);
   logic                   req_i;
   logic                   req_block_i;
   logic                   rw_i;
   logic [BW_ADDR-1:0]     add_i;
   logic                   ready_req_o;
   logic                   ready_read_o;
   logic                   read_i;
   logic [BW_DATA-1:0]     data_o;
   logic                   ready_write_o;
   logic                   write_i;
   logic [BW_DATA-1:0]     data_i;
   logic [BW_MEM_ADDR-1:0] mem_addr_o;
   logic                   mem_wren_o;
   logic [BW_DATA-1:0]     mem_data_o;
   logic [BW_DATA-1:0]     mem_data_i;
   logic                   err_o;

   modport slave (
      input  req_i, req_block_i, rw_i, add_i, read_i, write_i, data_i, mem_data_i,
      output ready_req_o, ready_read_o, data_o, ready_write_o,
             mem_addr_o, mem_wren_o, mem_data_o, err_o
   );

   modport master (
      output req_i, req_block_i, rw_i, add_i, read_i, write_i, data_i, mem_data_i,
      input  ready_req_o, ready_read_o, data_o, ready_write_o,
             mem_addr_o, mem_wren_o, mem_data_o, err_o
   );
endinterface

// File: rtl/internal_mem_resp_fifo.sv
// First-word fall-through synchronous FIFO; pointers carry an extra wrap bit.
module internal_mem_resp_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign count     = wr_ptr_r - rd_ptr_r;
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (count == (AW+1)'(DEPTH));
   assign dout      = mem_r[rd_ptr_r[AW-1:0]];
   assign do_pop_s  = pop && !empty;
   // a full FIFO still takes a word when the head leaves in the same cycle
   assign do_push_s = push && (!full || do_pop_s);

   // pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
   end

   // storage write
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
   end
endmodule

// File: rtl/internal_mem_responder.sv
// Memory-side responder: moves single words or blocks between a cache port and a
// synchronous SRAM through a data FIFO (SRAM->FIFO->cache on read, reverse on write).
module internal_mem_responder
   import internal_mem_responder_pkg::*;
#(
   parameter int BW_ADDR     = BW_WORD_ADDR,
   parameter int BW_BLOCK    = BW_BLOCK_LOG2,
   parameter int BW_MEM_ADDR = 14,
   parameter int FIFO_DEPTH  = 8
)(
   input logic                    clock_i,
   input logic                    reset_i,
   internal_mem_responder_if.slave bus
);
   localparam int BW_CNT  = BW_BLOCK + 1;
   localparam int BW_FCNT = $clog2(FIFO_DEPTH) + 1;
   localparam int BW_SUM  = BW_FCNT + 1;
   localparam logic [BW_CNT-1:0] LEN_BLK = BW_CNT'(2 ** BW_BLOCK);
   localparam logic [BW_CNT-1:0] LEN_ONE = BW_CNT'(1);

   state_e                 state_r, state_nx_s;
   logic                   ready_req_r, err_r;
   logic [BW_MEM_ADDR-1:0] base_r, mem_addr_r, addr_nx_s, req_base_s;
   logic [BW_CNT-1:0]      len_r, iss_r, rcv_r, wr_r;
   logic                   addr_vld_r, q_vld_r;
   logic                   mem_wren_r;
   logic [BW_DATA-1:0]     mem_data_r;
   logic                   accept_s, issue_s, addr_ld_s, wren_nx_s, err_s, room_s;
   logic                   ready_read_s, ready_write_s;
   logic                   fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
   logic [BW_DATA-1:0]     fifo_din_s, fifo_dout_s;
   logic [BW_FCNT-1:0]     fifo_count_s;
   logic                   unused_add_s;

   internal_mem_resp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BW_DATA)) u_fifo (
      .clk   (clock_i),
      .rst   (reset_i),
      .push  (fifo_push_s),
      .din   (fifo_din_s),
      .pop   (fifo_pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign unused_add_s  = ^bus.add_i[BW_ADDR-1:BW_MEM_ADDR];
   assign accept_s      = bus.req_i && ready_req_r;
   assign req_base_s    = bus.req_block_i ? {bus.add_i[BW_MEM_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}}
                                          : bus.add_i[BW_MEM_ADDR-1:0];
   assign ready_read_s  = (state_r == ST_READ) && !fifo_empty_s;
   assign ready_write_s = (state_r == ST_WRITE) && !fifo_full_s && (rcv_r < len_r);
   // words already queued plus those still in the SRAM pipe must fit in the FIFO
   assign room_s = (BW_SUM'(fifo_count_s) + BW_SUM'(addr_vld_r) + BW_SUM'(q_vld_r))
                   < BW_SUM'(FIFO_DEPTH);
   assign err_s  = (bus.req_i && !ready_req_r) || (bus.read_i && !ready_read_s)
                || (bus.write_i && !ready_write_s);

   assign bus.ready_req_o   = ready_req_r;
   assign bus.ready_read_o  = ready_read_s;
   assign bus.ready_write_o = ready_write_s;
   assign bus.data_o        = ready_read_s ? fifo_dout_s : '0;
   assign bus.mem_addr_o    = mem_addr_r;
   assign bus.mem_wren_o    = mem_wren_r;
   assign bus.mem_data_o    = mem_data_r;
   assign bus.err_o         = err_r;

   // state register
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_r <= ST_IDLE;
      else         state_r <= state_nx_s;
   end

   // next state, SRAM issue and FIFO control
   always_comb begin
      state_nx_s  = state_r;
      issue_s     = 1'b0;
      addr_ld_s   = 1'b0;
      addr_nx_s   = mem_addr_r;
      fifo_push_s = 1'b0;
      fifo_din_s  = bus.mem_data_i;
      fifo_pop_s  = 1'b0;
      wren_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && bus.rw_i) begin
               state_nx_s = ST_WRITE;
            end else if (accept_s) begin
               state_nx_s = ST_READ;
               issue_s    = 1'b1;
               addr_ld_s  = 1'b1;
               addr_nx_s  = req_base_s;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_READ: begin
            fifo_push_s = q_vld_r;
            fifo_pop_s  = bus.read_i && ready_read_s;
            if ((iss_r < len_r) && room_s) begin
               issue_s   = 1'b1;
               addr_ld_s = 1'b1;
               addr_nx_s = base_r + BW_MEM_ADDR'(iss_r);
            end else if ((iss_r == len_r) && !addr_vld_r && !q_vld_r &&
                         (fifo_empty_s || ((fifo_count_s == BW_FCNT'(1)) && fifo_pop_s))) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_READ;
            end
         end
         ST_WRITE: begin
            fifo_din_s  = bus.data_i;
            fifo_push_s = bus.write_i && ready_write_s;
            if (wr_r == len_r) begin
               state_nx_s = ST_IDLE;
            end else if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               wren_nx_s  = 1'b1;
               addr_ld_s  = 1'b1;
               addr_nx_s  = base_r + BW_MEM_ADDR'(wr_r);
            end else begin
               state_nx_s = ST_WRITE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // transfer counters, SRAM pipeline and registered outputs
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         ready_req_r <= 1'b0;
         err_r       <= 1'b0;
         base_r      <= '0;
         len_r       <= '0;
         iss_r       <= '0;
         rcv_r       <= '0;
         wr_r        <= '0;
         addr_vld_r  <= 1'b0;
         q_vld_r     <= 1'b0;
         mem_addr_r  <= '0;
         mem_wren_r  <= 1'b0;
         mem_data_r  <= '0;
      end else begin
         ready_req_r <= (state_nx_s == ST_IDLE);
         err_r       <= err_r | err_s;
         addr_vld_r  <= issue_s;
         q_vld_r     <= addr_vld_r;
         mem_wren_r  <= wren_nx_s;
         if (addr_ld_s) mem_addr_r <= addr_nx_s;
         if (wren_nx_s) mem_data_r <= fifo_dout_s;
         if (accept_s) begin
            base_r <= req_base_s;
            len_r  <= bus.req_block_i ? LEN_BLK : LEN_ONE;
            iss_r  <= bus.rw_i ? BW_CNT'(0) : BW_CNT'(1);
            rcv_r  <= '0;
            wr_r   <= '0;
         end else begin
            if (issue_s) iss_r <= iss_r + BW_CNT'(1);
            if (fifo_push_s && (state_r == ST_WRITE)) rcv_r <= rcv_r + BW_CNT'(1);
            if (wren_nx_s) wr_r <= wr_r + BW_CNT'(1);
         end
      end
   end
endmodule

// File: tb/tb_internal_mem_responder.sv
// Scoreboard bench: one responder with an 8-deep FIFO and one with a 2-deep FIFO.
module tb_internal_mem_responder;
   logic clk, rst;
   logic sel, req, blk, rw, rd, wr;
   logic [15:0] add;
   logic [31:0] wdata;
   logic        ld_en;
   logic [13:0] ld_addr;
   logic [31:0] ld_data;
   logic        rdy_req, rdy_read, rdy_write, wren, err;
   logic [31:0] dout, mdata;
   logic [13:0] maddr;
   logic [31:0] sram_a [16384];
   logic [31:0] sram_b [16384];
   logic [31:0] rq[$];
   logic [45:0] wq[$];
   logic [31:0] wdat [4];
   int n_vec, n_err, wren_cnt;

   internal_mem_responder_if ifc_a ();
   internal_mem_responder_if ifc_b ();

   internal_mem_responder #(.FIFO_DEPTH(8)) dut_a (.clock_i(clk), .reset_i(rst), .bus(ifc_a.slave));
   internal_mem_responder #(.FIFO_DEPTH(2)) dut_b (.clock_i(clk), .reset_i(rst), .bus(ifc_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // route cache strobes to the selected responder and mux its outputs back
   always_comb begin
      ifc_a.req_i = req && !sel;  ifc_b.req_i = req && sel;
      ifc_a.read_i = rd && !sel;  ifc_b.read_i = rd && sel;
      ifc_a.write_i = wr && !sel; ifc_b.write_i = wr && sel;
      ifc_a.req_block_i = blk; ifc_b.req_block_i = blk;
      ifc_a.rw_i = rw;         ifc_b.rw_i = rw;
      ifc_a.add_i = add;       ifc_b.add_i = add;
      ifc_a.data_i = wdata;    ifc_b.data_i = wdata;
      rdy_req   = sel ? ifc_b.ready_req_o   : ifc_a.ready_req_o;
      rdy_read  = sel ? ifc_b.ready_read_o  : ifc_a.ready_read_o;
      rdy_write = sel ? ifc_b.ready_write_o : ifc_a.ready_write_o;
      wren      = sel ? ifc_b.mem_wren_o    : ifc_a.mem_wren_o;
      err       = sel ? ifc_b.err_o         : ifc_a.err_o;
      dout      = sel ? ifc_b.data_o        : ifc_a.data_o;
      mdata     = sel ? ifc_b.mem_data_o    : ifc_a.mem_data_o;
      maddr     = sel ? ifc_b.mem_addr_o    : ifc_a.mem_addr_o;
   end

   // synchronous SRAM models with a preload port
   always @(posedge clk) begin
      if (ld_en) begin
         sram_a[ld_addr] <= ld_data;
         sram_b[ld_addr] <= ld_data;
      end
      if (ifc_a.mem_wren_o) sram_a[ifc_a.mem_addr_o] <= ifc_a.mem_data_o;
      if (ifc_b.mem_wren_o) sram_b[ifc_b.mem_addr_o] <= ifc_b.mem_data_o;
      ifc_a.mem_data_i <= sram_a[ifc_a.mem_addr_o];
      ifc_b.mem_data_i <= sram_b[ifc_b.mem_addr_o];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one cycle, then check any SRAM write against the write scoreboard
   task automatic tick();
      @(posedge clk);
      #1;
      if (wren) begin
         wren_cnt++;
         if (wq.size() == 0) check_val("wren_extra", 64'(wren), 64'd0);
         else check_val("sram_wr", {maddr, mdata}, wq.pop_front());
      end
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 50 && !rdy_req; c++) tick();
      check_val("idle_timeout", 64'(rdy_req), 64'd1);
   endtask

   task automatic do_read(input logic s, input logic [15:0] a, input logic b,
                          input int stall, input logic [13:0] hold);
      int lat, gaps, left;
      logic seen;
      sel = s;
      wait_idle();
      req = 1'b1; blk = b; rw = 1'b0; add = a;
      tick();
      req = 1'b0;
      lat = 0; gaps = 0; left = stall; seen = 1'b0;
      for (int c = 0; c < 100 && rq.size() > 0; c++) begin
         tick();
         rd = 1'b0;
         if (!seen) lat++;
         if (rdy_read) begin
            if (!seen) begin
               seen = 1'b1;
               check_val("rd_latency", 64'(lat), 64'd2);
            end
            if (left > 0) begin
               left--;
               if (left == 0) check_val("issue_hold", 64'(maddr), 64'(hold));
            end else begin
               check_val("rd_data", 64'(dout), 64'(rq.pop_front()));
               rd = 1'b1;
            end
         end else if (seen && stall == 0) begin
            gaps++;
         end
      end
      tick();
      rd = 1'b0;
      check_val("rd_timeout", 64'(rq.size()), 64'd0);
      rq.delete();
      if (stall == 0) check_val("rd_gaps", 64'(gaps), 64'd0);
      check_val("rd_ready_req", 64'(rdy_req), 64'd1);
   endtask

   task automatic do_write(input logic s, input logic [15:0] a, input logic b,
                           input int n_stop, input logic inj_req);
      int n, pushed, w0, lim;
      logic [13:0] base;
      sel = s;
      n = b ? 4 : 1;
      lim = (n_stop != 0) ? n_stop : n;
      base = b ? {a[13:2], 2'b00} : a[13:0];
      pushed = 0;
      wait_idle();
      w0 = wren_cnt;
      req = 1'b1; blk = b; rw = 1'b1; add = a;
      tick();
      req = 1'b0;
      for (int c = 0; c < 60 && pushed < lim; c++) begin
         wr = 1'b0;
         if (rdy_write) begin
            wr = 1'b1;
            wdata = wdat[pushed];
            wq.push_back({base + 14'(pushed), wdat[pushed]});
            pushed++;
         end
         req = inj_req && (pushed == 2);
         tick();
         wr = 1'b0;
         req = 1'b0;
      end
      check_val("wr_push_timeout", 64'(pushed), 64'(lim));
      if (n_stop == 0) begin
         for (int c = 0; c < 20 && !rdy_req; c++) tick();
         check_val("wr_ready_req", 64'(rdy_req), 64'd1);
         check_val("wr_pending", 64'(wq.size()), 64'd0);
         check_val("wren_cycles", 64'(wren_cnt - w0), 64'(n));
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; wren_cnt = 0;
      sel = 1'b0; req = 1'b0; blk = 1'b0; rw = 1'b0; rd = 1'b0; wr = 1'b0;
      add = 16'h0000; wdata = 32'h0; ld_en = 1'b0; ld_addr = 14'h0; ld_data = 32'h0;
      rst = 1'b1;
      tick();
      check_val("rst_ready_req", 64'(rdy_req), 64'd0);
      check_val("rst_ready_read", 64'(rdy_read), 64'd0);
      check_val("rst_ready_write", 64'(rdy_write), 64'd0);
      check_val("rst_outputs", {maddr, wren, err}, 64'd0);
      check_val("rst_data", {dout, mdata}, 64'd0);
      preload(14'h0123, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) preload(14'h0044 + 14'(i), 32'(i + 1));
      preload(14'h0090, 32'h11111111);
      rst = 1'b0;
      tick();
      check_val("ready_after_rst", 64'(rdy_req), 64'd1);

      // single-word read
      rq.push_back(32'hDEADBEEF);
      do_read(1'b0, 16'h0123, 1'b0, 0, 14'h0);
      // block read, no stall
      for (int i = 0; i < 4; i++) rq.push_back(32'(i + 1));
      do_read(1'b0, 16'h0047, 1'b1, 0, 14'h0);
      // block read on the 2-deep responder with a 10-cycle cache stall
      for (int i = 0; i < 4; i++) rq.push_back(32'(i + 1));
      do_read(1'b1, 16'h0047, 1'b1, 10, 14'h0045);

      // block write
      wdat[0] = 32'hA0000001; wdat[1] = 32'hB0000002;
      wdat[2] = 32'hC0000003; wdat[3] = 32'hD0000004;
      do_write(1'b0, 16'h0080, 1'b1, 0, 1'b0);
      for (int i = 0; i < 4; i++) check_val("sram_block", 64'(sram_a[14'h0080 + 14'(i)]), 64'(wdat[i]));
      check_val("err_clean", 64'(err), 64'd0);

      // protocol violations: read_i while idle, req_i during a write
      sel = 1'b0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check_val("err_read_idle", 64'(err), 64'd1);
      wdat[0] = 32'h01010101; wdat[1] = 32'h02020202;
      wdat[2] = 32'h03030303; wdat[3] = 32'h04040404;
      do_write(1'b0, 16'h00A0, 1'b1, 0, 1'b1);
      for (int i = 0; i < 4; i++) check_val("sram_viol", 64'(sram_a[14'h00A0 + 14'(i)]), 64'(wdat[i]));
      check_val("err_sticky", 64'(err), 64'd1);

      // reset after two of four write words
      wdat[0] = 32'hE0E0E0E0; wdat[1] = 32'hF0F0F0F0;
      do_write(1'b0, 16'h0090, 1'b1, 2, 1'b0);
      rst = 1'b1;
      #1;
      check_val("abort_outputs", {maddr, wren, rdy_req, rdy_write, err}, 64'd0);
      check_val("abort_mdata", 64'(mdata), 64'd0);
      wq.delete();
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      check_val("abort_ready_req", 64'(rdy_req), 64'd1);
      check_val("abort_fifo_empty", 64'(rdy_read), 64'd0);
      check_val("abort_no_write", 64'(sram_a[14'h0090]), 64'h11111111);
      rq.push_back(32'hDEADBEEF);
      do_read(1'b0, 16'h0123, 1'b0, 0, 14'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
